alu_driver: RTL and testbench



---
 rtl/alu_pkg.sv | 94 +++++++++
 rtl/alu_driver_encoder.sv | 41 ++++
 rtl/alu_driver.sv | 149 ++++++++++++++
 tb/tb_alu_driver.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU command driver:
//   - alu_op_e     : abstract operation codes accepted on the command port
//   - MODE_*       : ALU mode bytes {op_sel[4:0], cin, inv_b, inv_a}
//   - SEL_*        : op_sel field values inside the mode byte
//   - ST_*         : bit positions in the ALU status byte
//   - drv_state_e  : driver FSM states
//   - alu_golden() : reference ALU behaviour, compiled only when
//                    ALU_DRV_SELFCHECK_EN is defined
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_INC   = 4'd2,
        OP_DEC   = 4'd3,
        OP_AND   = 4'd4,
        OP_OR    = 4'd5,
        OP_XOR   = 4'd6,
        OP_NOTA  = 4'd7,
        OP_PASSA = 4'd8,
        OP_PASSB = 4'd9,
        OP_NEG   = 4'd10,
        OP_NAND  = 4'd11
    } alu_op_e;

    localparam logic [7:0] MODE_ADD   = 8'h08;
    localparam logic [7:0] MODE_SUB   = 8'h0E;
    localparam logic [7:0] MODE_INC   = 8'h0C;
    localparam logic [7:0] MODE_DEC   = 8'h0A;
    localparam logic [7:0] MODE_AND   = 8'h10;
    localparam logic [7:0] MODE_OR    = 8'h18;
    localparam logic [7:0] MODE_XOR   = 8'h20;
    localparam logic [7:0] MODE_NOTA  = 8'h29;
    localparam logic [7:0] MODE_PASSA = 8'h28;
    localparam logic [7:0] MODE_PASSB = 8'h30;
    localparam logic [7:0] MODE_NEG   = 8'h0D;
    localparam logic [7:0] MODE_NAND  = 8'h1B;

    // op_sel field (mode[7:3]) values
    localparam logic [4:0] SEL_ARITH = 5'd1;
    localparam logic [4:0] SEL_AND   = 5'd2;
    localparam logic [4:0] SEL_OR    = 5'd3;
    localparam logic [4:0] SEL_XOR   = 5'd4;
    localparam logic [4:0] SEL_PASSA = 5'd5;
    localparam logic [4:0] SEL_PASSB = 5'd6;

    localparam int ST_ZERO = 0;
    localparam int ST_OVF  = 1;
    localparam int ST_NEG  = 2;
    localparam int ST_PAR  = 3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } drv_state_e;

`ifdef ALU_DRV_SELFCHECK_EN
    // Reference ALU: returns {parity, neg, ovf, zero, result[7:0]}.
    // Operand inversion and carry-in come from the low mode bits; op_sel
    // picks the function. Overflow is only meaningful for the adder.
    function automatic logic [11:0] alu_golden(input logic [7:0] a,
                                               input logic [7:0] b,
                                               input logic [7:0] mode);
        logic [7:0] ta;
        logic [7:0] tb;
        logic [7:0] sum;
        logic [7:0] r;
        logic       v;
        ta  = mode[0] ? ~a : a;
        tb  = mode[1] ? ~b : b;
        sum = ta + tb + {7'd0, mode[2]};
        v   = 1'b0;
        case (mode[7:3])
            SEL_ARITH: begin
                r = sum;
                v = (ta[7] == tb[7]) && (sum[7] != ta[7]);
            end
            SEL_AND:   r = ta & tb;
            SEL_OR:    r = ta | tb;
            SEL_XOR:   r = ta ^ tb;
            SEL_PASSA: r = ta;
            SEL_PASSB: r = tb;
            default:   r = 8'h00;
        endcase
        return {~^r, r[7], v, (r == 8'h00), r};
    endfunction
`endif

endpackage

// File: rtl/alu_driver_encoder.sv
// ---------------------------------------------------------------------------
// alu_op_encoder
// Combinational map from an abstract opcode to the ALU mode byte.
// Ports:
//   op      in  4  operation code (alu_op_e)
//   b_zero  out 1  operand B must be forced to 0x00 (unary ops)
//   mode    out 8  ALU mode byte
//   illegal out 1  opcode 12..15, nothing is issued to the ALU
// ---------------------------------------------------------------------------
module alu_op_encoder
    import alu_pkg::*;
(
    input  logic [3:0] op,
    output logic       b_zero,
    output logic [7:0] mode,
    output logic       illegal
);

    // Opcode to mode-byte lookup; unknown codes flag illegal with a safe mode.
    always_comb begin
        b_zero  = 1'b0;
        mode    = MODE_PASSA;
        illegal = 1'b0;
        case (op)
            OP_ADD:   mode = MODE_ADD;
            OP_SUB:   mode = MODE_SUB;
            OP_INC:   begin mode = MODE_INC; b_zero = 1'b1; end
            OP_DEC:   begin mode = MODE_DEC; b_zero = 1'b1; end
            OP_AND:   mode = MODE_AND;
            OP_OR:    mode = MODE_OR;
            OP_XOR:   mode = MODE_XOR;
            OP_NOTA:  mode = MODE_NOTA;
            OP_PASSA: mode = MODE_PASSA;
            OP_PASSB: mode = MODE_PASSB;
            OP_NEG:   begin mode = MODE_NEG; b_zero = 1'b1; end
            OP_NAND:  mode = MODE_NAND;
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_driver.sv
// ---------------------------------------------------------------------------
// alu_driver
// Command-side initiator for the registered 8-bit ALU. Accepts one abstract
// operation at a time, drives the ALU operand/mode bytes for one cycle,
// captures the registered result and status, and returns them on a
// valid/ready response port. Sequence: IDLE -> ISSUE -> CAPTURE -> RESP.
// Illegal opcodes skip the ALU and respond the cycle after acceptance.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/ready/op/a/b    command port
//   alu_a/b/mode              ALU operands and mode byte (registered)
//   alu_out, alu_status       ALU registered result and status
//   resp_valid/ready          response handshake
//   resp_data/flags/err       result, {parity,neg,ovf,zero}, error
//
// Configuration macro: ALU_DRV_SELFCHECK_EN -- when defined, a golden model
// checks each captured result and flags; a mismatch sets resp_err.
// ---------------------------------------------------------------------------
module alu_driver
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [7:0] alu_mode,
    input  logic [7:0] alu_out,
    input  logic [7:0] alu_status,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [7:0] resp_data,
    output logic [3:0] resp_flags,
    output logic       resp_err
);

    drv_state_e state_r;
    logic [7:0] alu_a_r;
    logic [7:0] alu_b_r;
    logic [7:0] alu_mode_r;
    logic [7:0] resp_data_r;
    logic [3:0] resp_flags_r;
    logic       resp_err_r;

    logic       enc_b_zero_s;
    logic [7:0] enc_mode_s;
    logic       enc_illegal_s;
    logic       arith_s;
    logic [3:0] cap_flags_s;
    logic       mismatch_s;
    logic       unused_status_s;

    alu_op_encoder u_enc (
        .op      (cmd_op),
        .b_zero  (enc_b_zero_s),
        .mode    (enc_mode_s),
        .illegal (enc_illegal_s)
    );

    // The ALU's overflow bit is only refreshed by the adder; for every other
    // op_sel value it is stale and must not reach the consumer.
    assign arith_s     = (alu_mode_r[7:3] == SEL_ARITH);
    assign cap_flags_s = {alu_status[ST_PAR], alu_status[ST_NEG],
                          alu_status[ST_OVF] & arith_s, alu_status[ST_ZERO]};
    assign unused_status_s = ^alu_status[7:4];

`ifdef ALU_DRV_SELFCHECK_EN
    logic [11:0] golden_s;
    logic [3:0]  golden_flags_s;

    // Golden result for the operands the ALU sampled during ISSUE.
    always_comb begin
        golden_s       = alu_golden(alu_a_r, alu_b_r, alu_mode_r);
        golden_flags_s = {golden_s[11], golden_s[10],
                          golden_s[9] & arith_s, golden_s[8]};
        if ((alu_out != golden_s[7:0]) || (cap_flags_s != golden_flags_s)) begin
            mismatch_s = 1'b1;
        end else begin
            mismatch_s = 1'b0;
        end
    end
`else
    assign mismatch_s = 1'b0;
`endif

    // Driver FSM plus ALU-side and response-side registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            alu_a_r      <= 8'h00;
            alu_b_r      <= 8'h00;
            alu_mode_r   <= MODE_PASSA;
            resp_data_r  <= 8'h00;
            resp_flags_r <= 4'h0;
            resp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (enc_illegal_s) begin
                            // Nothing goes to the ALU; answer immediately.
                            resp_data_r  <= 8'h00;
                            resp_flags_r <= 4'h0;
                            resp_err_r   <= 1'b1;
                            state_r      <= S_RESP;
                        end else begin
                            alu_a_r    <= cmd_a;
                            alu_b_r    <= enc_b_zero_s ? 8'h00 : cmd_b;
                            alu_mode_r <= enc_mode_s;
                            state_r    <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    state_r <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    resp_data_r  <= alu_out;
                    resp_flags_r <= cap_flags_s;
                    resp_err_r   <= mismatch_s;
                    state_r      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = (state_r == S_IDLE);
    assign resp_valid = (state_r == S_RESP);
    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign alu_mode   = alu_mode_r;
    assign resp_data  = resp_data_r;
    assign resp_flags = resp_flags_r;
    assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_alu_driver.sv
// ---------------------------------------------------------------------------
// tb_alu_driver
// Directed, table-driven bench for alu_driver. A small registered ALU model
// answers the driver's alu_* outputs; its overflow bit is held stale for
// non-adder modes, as the real ALU does. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_alu_driver;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_mode;
    logic [7:0] alu_out;
    logic [7:0] alu_status;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_data;
    logic [3:0] resp_flags;
    logic       resp_err;

    int checks;
    int errors;

    alu_driver dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_mode   (alu_mode),
        .alu_out    (alu_out),
        .alu_status (alu_status),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_flags (resp_flags),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- registered ALU model ----------------
    logic [7:0] m_ta, m_tb, m_sum, m_r, alu_q, st_q;
    logic       m_v;
    logic       corrupt;

    always_comb begin
        m_ta  = alu_mode[0] ? ~alu_a : alu_a;
        m_tb  = alu_mode[1] ? ~alu_b : alu_b;
        m_sum = m_ta + m_tb + {7'd0, alu_mode[2]};
        m_v   = st_q[1];
        case (alu_mode[7:3])
            5'd1: begin
                m_r = m_sum;
                m_v = (m_ta[7] == m_tb[7]) && (m_sum[7] != m_ta[7]);
            end
            5'd2:    m_r = m_ta & m_tb;
            5'd3:    m_r = m_ta | m_tb;
            5'd4:    m_r = m_ta ^ m_tb;
            5'd5:    m_r = m_ta;
            5'd6:    m_r = m_tb;
            default: m_r = 8'h00;
        endcase
    end

    initial st_q = 8'h00;
    always @(posedge clk) begin
        alu_q <= m_r;
        st_q  <= {4'h0, ~^m_r, m_r[7], m_v, (m_r == 8'h00)};
    end

    assign alu_out    = corrupt ? 8'h55 : alu_q;
    assign alu_status = st_q;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present a command, wait for acceptance, then count cycles to resp_valid.
    task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic ack();
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] data;
        logic [3:0] flags;
        logic       err;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [7:0] mode_before;

        checks = 0;
        errors = 0;
        // flags = {parity, neg, ovf, zero}
        vecs[0]  = '{4'd0,  8'h7F, 8'h01, 8'h80, 4'b0110, 1'b0}; // ADD overflow
        vecs[1]  = '{4'd4,  8'hF0, 8'h3C, 8'h30, 4'b1000, 1'b0}; // AND, stale ovf masked
        vecs[2]  = '{4'd1,  8'h05, 8'h05, 8'h00, 4'b1001, 1'b0}; // SUB to zero
        vecs[3]  = '{4'd2,  8'h10, 8'hAA, 8'h11, 4'b1000, 1'b0}; // INC ignores b
        vecs[4]  = '{4'd3,  8'h00, 8'h55, 8'hFF, 4'b1100, 1'b0}; // DEC wrap
        vecs[5]  = '{4'd5,  8'hA0, 8'h05, 8'hA5, 4'b1100, 1'b0}; // OR
        vecs[6]  = '{4'd6,  8'hFF, 8'h0F, 8'hF0, 4'b1100, 1'b0}; // XOR
        vecs[7]  = '{4'd7,  8'h0F, 8'h33, 8'hF0, 4'b1100, 1'b0}; // NOTA
        vecs[8]  = '{4'd8,  8'h81, 8'h33, 8'h81, 4'b1100, 1'b0}; // PASSA
        vecs[9]  = '{4'd9,  8'h81, 8'h7E, 8'h7E, 4'b1000, 1'b0}; // PASSB
        vecs[10] = '{4'd10, 8'h80, 8'h12, 8'h80, 4'b0110, 1'b0}; // NEG of -128
        vecs[11] = '{4'd11, 8'hFF, 8'hFF, 8'h00, 4'b1001, 1'b0}; // NAND, stale ovf masked
        vecs[12] = '{4'd13, 8'h12, 8'h34, 8'h00, 4'b0000, 1'b1}; // illegal
        vecs[13] = '{4'd15, 8'hFF, 8'hFF, 8'h00, 4'b0000, 1'b1}; // illegal

        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = 4'd0;
        cmd_a      = 8'h00;
        cmd_b      = 8'h00;
        resp_ready = 1'b0;
        corrupt    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready",  {31'd0, cmd_ready},  32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_alu_mode",   {24'd0, alu_mode},   32'h28);
        check("rst_alu_a",      {24'd0, alu_a},      32'h00);
        check("rst_alu_b",      {24'd0, alu_b},      32'h00);
        check("rst_resp_data",  {24'd0, resp_data},  32'h00);
        check("rst_resp_flags", {28'd0, resp_flags}, 32'h0);
        check("rst_resp_err",   {31'd0, resp_err},   32'd0);
        rst = 1'b0;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 14; i++) begin
            mode_before = alu_mode;
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            check($sformatf("v%0d_latency", i), lat, vecs[i].err ? 32'd1 : 32'd3);
            check($sformatf("v%0d_data", i),  {24'd0, resp_data},  {24'd0, vecs[i].data});
            check($sformatf("v%0d_flags", i), {28'd0, resp_flags}, {28'd0, vecs[i].flags});
            check($sformatf("v%0d_err", i),   {31'd0, resp_err},   {31'd0, vecs[i].err});
            if (vecs[i].err) begin
                check($sformatf("v%0d_mode_held", i), {24'd0, alu_mode}, {24'd0, mode_before});
            end
            ack();
            check($sformatf("v%0d_idle", i), {30'd0, resp_valid, cmd_ready}, 32'd1);
        end

        // ---------------- response back-pressure ----------------
        run_op(4'd2, 8'hFF, 8'h00, lat);
        check("stall_latency", lat, 32'd3);
        cmd_valid = 1'b1;
        cmd_op    = 4'd0;
        cmd_a     = 8'h01;
        cmd_b     = 8'h02;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall%0d_valid", i), {31'd0, resp_valid}, 32'd1);
            check($sformatf("stall%0d_ready", i), {31'd0, cmd_ready},  32'd0);
            check($sformatf("stall%0d_data", i),  {24'd0, resp_data},  32'h00);
            check($sformatf("stall%0d_flags", i), {28'd0, resp_flags}, 32'h9);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check("turn_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("turn_accepted", {31'd0, cmd_ready}, 32'd0);
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("turn_latency", lat, 32'd3);
        check("turn_data", {24'd0, resp_data}, 32'h03);
        check("turn_flags", {28'd0, resp_flags}, 32'h8);
        ack();

        // ---------------- reset during CAPTURE ----------------
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 4'd3;
        cmd_a     = 8'h10;
        cmd_b     = 8'h00;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rstcap_issue_mode", {24'd0, alu_mode}, 32'h0A);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rstcap_cmd_ready",  {31'd0, cmd_ready},  32'd1);
        check("rstcap_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rstcap_alu_mode",   {24'd0, alu_mode},   32'h28);
        check("rstcap_alu_a",      {24'd0, alu_a},      32'h00);
        check("rstcap_resp_err",   {31'd0, resp_err},   32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("rstcap_no_resp%0d", i), {31'd0, resp_valid}, 32'd0);
        end

        // ---------------- corrupted ALU result ----------------
        corrupt = 1'b1;
        run_op(4'd0, 8'h01, 8'h01, lat);
        corrupt = 1'b0;
        check("corrupt_latency", lat, 32'd3);
        check("corrupt_data", {24'd0, resp_data}, 32'h55);
`ifdef ALU_DRV_SELFCHECK_EN
        check("corrupt_err", {31'd0, resp_err}, 32'd1);
`else
        check("corrupt_err", {31'd0, resp_err}, 32'd0);
`endif
        ack();

        // A clean ADD afterwards must not carry the error over.
        run_op(4'd0, 8'h01, 8'h01, lat);
        check("clean_data", {24'd0, resp_data}, 32'h02);
        check("clean_err",  {31'd0, resp_err},  32'd0);
        ack();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
